// File: rtl/uart_boot_pkg.sv
// Shared types and protocol constants for the UART boot loader.
// Frame states, receiver states and the sync/status byte values live here.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h4B;
  localparam logic [7:0] NAK_BYTE  = 8'h45;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: two-flop synchronizer, mid-bit sampling, glitch
// rejection on the start bit, one-cycle byte_valid or frame_err per byte.
module uart_byte_rx
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);

  logic          rxMeta_q, rxSync_q, rxPrev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // The start bit is re-checked at its midpoint; later samples land mid-bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxSync_q && rxPrev_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxSync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d    = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          valid_d = rxSync_q;
          err_d   = !rxSync_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed image, writes it to program memory as
// 32-bit words while holding the CPU in reset, then answers with a status byte.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int BAUD_RATE      = 115200,
  parameter int MEMORY_SIZE    = 8192,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CPB_M1    = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(MEMORY_SIZE / 4);

  logic [7:0] rxByte;
  logic       byteValid, frameErr;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx),
    .data_o      (rxByte),
    .byte_valid_o(byteValid),
    .frame_err_o (frameErr)
  );

  boot_state_e   state_q, state_d;
  logic [7:0]    lenLo_q, lenLo_d;
  logic [15:0]   wordCount_q, wordCount_d;
  logic [15:0]   wordIdx_q, wordIdx_d;
  logic [1:0]    byteIdx_q, byteIdx_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    status_q, status_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    txFrame_q, txFrame_d;
  logic [CW-1:0] txClk_q, txClk_d;
  logic [3:0]    txBit_q, txBit_d;
  logic          memWe_q, memWe_d;
  logic [31:0]   memAddr_q, memAddr_d;
  logic [31:0]   memWdata_q, memWdata_d;
  logic          cpuRstN_q, cpuRstN_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lenLo_q     <= '0;
      wordCount_q <= '0;
      wordIdx_q   <= '0;
      byteIdx_q   <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      status_q    <= NAK_BYTE;
      timer_q     <= '0;
      txFrame_q   <= '1;
      txClk_q     <= '0;
      txBit_q     <= '0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      cpuRstN_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lenLo_q     <= lenLo_d;
      wordCount_q <= wordCount_d;
      wordIdx_q   <= wordIdx_d;
      byteIdx_q   <= byteIdx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      status_q    <= status_d;
      timer_q     <= timer_d;
      txFrame_q   <= txFrame_d;
      txClk_q     <= txClk_d;
      txBit_q     <= txBit_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      cpuRstN_q   <= cpuRstN_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  logic        inFrame, startResp;
  logic [7:0]  respStatus;
  logic [15:0] newLen;
  logic [31:0] assembled;

  always_comb begin
    state_d     = state_q;
    lenLo_d     = lenLo_q;
    wordCount_d = wordCount_q;
    wordIdx_d   = wordIdx_q;
    byteIdx_d   = byteIdx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    status_d    = status_q;
    txFrame_d   = txFrame_q;
    txClk_d     = txClk_q;
    txBit_d     = txBit_q;
    memWe_d     = 1'b0;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    cpuRstN_d   = cpuRstN_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    startResp   = 1'b0;
    respStatus  = NAK_BYTE;
    newLen      = {rxByte, lenLo_q};
    assembled   = {rxByte, word_q};
    inFrame     = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                  (state_q == ST_DATA)   || (state_q == ST_CSUM);
    timer_d     = (inFrame && !byteValid) ? timer_q + 1'b1 : '0;

    case (state_q)
      ST_IDLE: begin
        if (byteValid && rxByte == SYNC_BYTE) begin
          state_d   = ST_LEN_LO;
          done_d    = 1'b0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          cpuRstN_d = 1'b0;
          csum_d    = '0;
          wordIdx_d = '0;
          byteIdx_d = '0;
        end
      end
      ST_LEN_LO: begin
        if (byteValid) begin
          lenLo_d = rxByte;
          csum_d  = csum_q ^ rxByte;
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (byteValid) begin
          csum_d      = csum_q ^ rxByte;
          wordCount_d = newLen;
          if ({1'b0, newLen} > MAX_WORDS) startResp = 1'b1;
          else if (newLen == 16'd0)       state_d   = ST_CSUM;
          else                            state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byteValid) begin
          csum_d    = csum_q ^ rxByte;
          word_d    = assembled[31:8];
          byteIdx_d = byteIdx_q + 2'd1;
          if (byteIdx_q == 2'd3) begin
            memWe_d    = 1'b1;
            memAddr_d  = {14'd0, wordIdx_q, 2'b00};
            memWdata_d = assembled;
            wordIdx_d  = wordIdx_q + 16'd1;
            if (wordIdx_q == wordCount_q - 16'd1) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (byteValid) begin
          startResp  = 1'b1;
          respStatus = (csum_q == rxByte) ? ACK_BYTE : NAK_BYTE;
        end
      end
      ST_RESP: begin
        if (txClk_q == CPB_M1) begin
          txClk_d   = '0;
          txFrame_d = {1'b1, txFrame_q[9:1]};
          txBit_d   = txBit_q + 4'd1;
          if (txBit_q == 4'd9) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            cpuRstN_d = 1'b1;
            done_d    = (status_q == ACK_BYTE);
            error_d   = (status_q != ACK_BYTE);
          end
        end else begin
          txClk_d = txClk_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A broken or stalled frame aborts whatever the byte path decided.
    if (inFrame && (frameErr || (timer_q == TO_M1 && !byteValid))) begin
      startResp  = 1'b1;
      respStatus = NAK_BYTE;
    end

    if (startResp) begin
      state_d   = ST_RESP;
      status_d  = respStatus;
      txFrame_d = {1'b1, respStatus, 1'b0};
      txClk_d   = '0;
      txBit_d   = '0;
    end
  end

  assign tx        = txFrame_q[0];
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign cpu_rst_n = cpuRstN_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: serial frame driver, a frame-level
// reference model of expected writes/status, a tx decoder and a write monitor.
module tb_uart_boot_loader;

  localparam int CLOCK_FREQ     = 1000;
  localparam int BAUD_RATE      = 100;
  localparam int MEMORY_SIZE    = 8192;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int CPB            = CLOCK_FREQ / BAUD_RATE;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLOCK_FREQ    (CLOCK_FREQ),
    .BAUD_RATE     (BAUD_RATE),
    .MEMORY_SIZE   (MEMORY_SIZE),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .tx       (tx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleCount = 0;
  int          sendEnd = 0;
  int          txFallCycle = 0;
  logic [7:0]  frameQ[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] expDataQ[$];
  logic [31:0] logAddrQ[$];
  logic [31:0] logDataQ[$];
  logic [7:0]  txGotQ[$];
  logic [7:0]  expStatus;
  logic [7:0]  lastStatus;
  logic [7:0]  decByte;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: event did not occur (got none, expected one)", name);
  endtask

  // Frame-level model: which whole words must land in memory and which status byte follows.
  task automatic modelFrame();
    int n;
    int sz;
    logic [7:0] cs;
    sz = frameQ.size();
    expStatus = 8'h45;
    if (sz < 3) return;
    n = int'({frameQ[2], frameQ[1]});
    if (n > MEMORY_SIZE / 4) return;
    for (int w = 0; w < n; w++) begin
      if (3 + 4 * w + 3 < sz) begin
        expAddrQ.push_back(32'(4 * w));
        expDataQ.push_back({frameQ[3+4*w+3], frameQ[3+4*w+2], frameQ[3+4*w+1], frameQ[3+4*w]});
      end
    end
    if (sz == 4 + 4 * n) begin
      cs = 8'h00;
      for (int i = 1; i < sz - 1; i++) cs = cs ^ frameQ[i];
      if (cs == frameQ[sz-1]) expStatus = 8'h4B;
    end
  endtask

  // Per-cycle compare: every write must match the model in order, CPU held exactly while busy.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cpu_rst_n_tracks_busy", {31'd0, cpu_rst_n}, {31'd0, !busy});
      if (mem_we) begin
        if (expAddrQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                   mem_addr, mem_wdata);
        end else begin
          checkOutput("write_addr", mem_addr, expAddrQ.pop_front());
          checkOutput("write_data", mem_wdata, expDataQ.pop_front());
        end
        logAddrQ.push_back(mem_addr);
        logDataQ.push_back(mem_wdata);
      end
    end
  end

  // Independent UART decoder on tx.
  initial begin
    forever begin
      @(negedge tx);
      txFallCycle = cycleCount;
      repeat (CPB / 2) @(negedge clk);
      checkOutput("tx_start_bit", {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        decByte[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      checkOutput("tx_stop_bit", {31'd0, tx}, 32'd1);
      checkOutput("cpu_held_during_stop", {31'd0, cpu_rst_n}, 32'd0);
      txGotQ.push_back(decByte);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendByte(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic applyStimulus();
    logAddrQ.delete();
    logDataQ.delete();
    lastStatus = 8'h00;
    txFallCycle = -1000000;
    modelFrame();
    foreach (frameQ[i]) sendByte(frameQ[i]);
    sendEnd = cycleCount;
  endtask

  task automatic waitResponse(input string name, input int maxCycles);
    int c;
    c = 0;
    while (txGotQ.size() == 0 && c < maxCycles) begin
      @(negedge clk);
      c++;
    end
    if (txGotQ.size() == 0) begin
      failNow({name, "_response_timeout"});
      return;
    end
    lastStatus = txGotQ.pop_front();
    checkOutput({name, "_status"}, {24'd0, lastStatus}, {24'd0, expStatus});
    c = 0;
    while (busy && c < 4 * CPB) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
    checkOutput({name, "_done"}, {31'd0, done}, {31'd0, expStatus == 8'h4B});
    checkOutput({name, "_error"}, {31'd0, error}, {31'd0, expStatus != 8'h4B});
    checkOutput({name, "_pending_writes"}, expAddrQ.size(), 32'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_tx"}, {31'd0, tx}, 32'd1);
    checkOutput({name, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    checkOutput({name, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({name, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({name, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] line noise in IDLE");
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    checkOutput("glitch_busy", {31'd0, busy}, 32'd0);
    sendByte(8'h00);
    sendByte(8'h11);
    repeat (20) @(negedge clk);
    checkOutput("noise_busy", {31'd0, busy}, 32'd0);
    checkOutput("noise_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    checkOutput("noise_no_response", txGotQ.size(), 32'd0);

    $display("[TB] good frame");
    frameQ = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    applyStimulus();
    waitResponse("good", 20 * CPB);
    checkOutput("good_status_literal", {24'd0, lastStatus}, 32'h4B);
    checkOutput("good_write_count", logAddrQ.size(), 32'd2);
    if (logAddrQ.size() == 2) begin
      checkOutput("good_w0_addr", logAddrQ[0], 32'd0);
      checkOutput("good_w0_data", logDataQ[0], 32'h00000013);
      checkOutput("good_w1_addr", logAddrQ[1], 32'd4);
      checkOutput("good_w1_data", logDataQ[1], 32'h0000006F);
    end

    $display("[TB] bad checksum");
    frameQ = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7F};
    applyStimulus();
    waitResponse("badcsum", 20 * CPB);
    checkOutput("badcsum_status_literal", {24'd0, lastStatus}, 32'h45);
    checkOutput("badcsum_write_count", logAddrQ.size(), 32'd2);

    $display("[TB] oversize length");
    frameQ = {8'hA5, 8'h01, 8'h08};
    applyStimulus();
    waitResponse("oversize", 20 * CPB);
    lat = txFallCycle - sendEnd;
    checkOutput("oversize_immediate", {31'd0, (lat >= -CPB) && (lat <= CPB)}, 32'd1);
    checkOutput("oversize_write_count", logAddrQ.size(), 32'd0);

    $display("[TB] stall timeout");
    frameQ = {8'hA5, 8'h01, 8'h00, 8'h13};
    applyStimulus();
    waitResponse("stall", TIMEOUT_CYCLES + 20 * CPB);
    lat = txFallCycle - sendEnd;
    checkOutput("stall_timeout_window",
                {31'd0, (lat >= TIMEOUT_CYCLES - CPB) && (lat <= TIMEOUT_CYCLES + CPB)}, 32'd1);

    $display("[TB] zero-length frame");
    frameQ = {8'hA5, 8'h00, 8'h00, 8'h00};
    applyStimulus();
    waitResponse("zerolen", 20 * CPB);
    checkOutput("zerolen_status_literal", {24'd0, lastStatus}, 32'h4B);

    $display("[TB] sync byte inside data");
    frameQ = {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01};
    applyStimulus();
    waitResponse("syncdata", 20 * CPB);
    checkOutput("syncdata_w0_data", (logDataQ.size() > 0) ? logDataQ[0] : 32'd0, 32'hA5A5A5A5);

    $display("[TB] reset during second word");
    frameQ = {8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    applyStimulus();
    rst = 1'b1;
    #2;
    checkResetValues("midreset");
    checkOutput("midreset_first_word_written", expAddrQ.size(), 32'd0);
    checkOutput("midreset_w0_data", (logDataQ.size() > 0) ? logDataQ[0] : 32'd0, 32'h44332211);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    checkOutput("midreset_no_response", txGotQ.size(), 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);

    frameQ = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    applyStimulus();
    waitResponse("afterreset", 20 * CPB);
    checkOutput("afterreset_write_count", logAddrQ.size(), 32'd2);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits upstream of the SoC on the FPGA top: owns the board `rx`/`tx` pins and a write port into the SoC program memory.
- Receives a framed program image over UART and writes it into memory as 32-bit words, holding the CPU in reset while loading.
- Answers with a one-byte status, then releases the CPU so it runs the new image without a bitstream rebuild.

Parameters:
- CLOCK_FREQ, 50000000: clk frequency in Hz.
- BAUD_RATE, 115200: UART bit rate. CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, integer-truncated (434).
- MEMORY_SIZE, 8192: target memory size in bytes. Max word count = MEMORY_SIZE/4.
- TIMEOUT_CYCLES, 5000000: max idle clocks between bytes inside a frame (100 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  UART receive line, asynchronous to clk, idle high.
- tx  out  1  UART transmit line, idle high.
- mem_we  out  1  one-cycle word write strobe.
- mem_addr  out  32  byte address, always word aligned.
- mem_wdata  out  32  write data.
- cpu_rst_n  out  1  active-low SoC reset request.
- busy  out  1  high while a frame is in progress or the response is being sent.
- done  out  1  sticky: last frame passed.
- error  out  1  sticky: last frame failed.

Behaviour:
- Reset values: tx=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=1, busy=0, done=0, error=0. FSM goes to IDLE. The async reset may hit mid-frame; everything returns to these values, with no partial response and no further writes.
- rx input: two-flop synchronizer.
- Start detection: falling edge starts a bit timer. Re-sample at CLKS_PER_BIT/2; if rx is high again, discard as a glitch.
- Data bits: sampled LSB first at CLKS_PER_BIT intervals after the mid-start point.
- Stop bit: sampled once. If it is 0, that is a framing error.
- Byte output: on a good stop bit, a byte-valid pulse lasts exactly one cycle.
- Frame format: 0xA5 sync, LEN_LO, LEN_HI (word count N, little endian), N×4 data bytes (little endian per word), then one CSUM byte. CSUM = XOR of LEN_LO, LEN_HI and all data bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, RESP.
- IDLE:
  - Discards every byte except 0xA5.
  - On 0xA5: clear done and error, set busy=1 and cpu_rst_n=0 in the next cycle, go to LEN_LO.
- LEN_HI:
  - If N > MEMORY_SIZE/4, go to RESP with status 'E'.
  - If N = 0, go to CSUM.
  - Otherwise go to DATA.
- DATA:
  - A 2-bit byte index shifts bytes into the word.
  - On the 4th byte: mem_we=1 for one cycle, mem_addr=word_idx*4, mem_wdata=assembled word, word_idx increments.
  - After word N-1, go to CSUM.
- CSUM: compare the running XOR with the received byte; status is 'K' (0x4B) on a match, 'E' (0x45) on a mismatch. Go to RESP.
- Framing error or timeout in any state other than IDLE/RESP: go to RESP with 'E'.
  - The timeout counter resets on each byte-valid pulse.
  - Timeout fires when the counter reaches TIMEOUT_CYCLES.
- RESP:
  - Transmits the status as 8N1 at the same baud: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks.
  - Bytes received during RESP are ignored.
  - After the stop bit: busy=0, cpu_rst_n=1, done=1 for 'K' or error=1 for 'E', return to IDLE.
- Memory contents written before an error are left as written; the CPU is still released.
- Only 0xA5 in IDLE starts a frame. Any 0xA5 byte inside a frame is treated as data.

Decomposition:
- Package uart_boot_pkg:
  - state enum.
  - SYNC_BYTE=8'hA5, ACK_BYTE=8'h4B, NAK_BYTE=8'h45.
- Sub-module uart_byte_rx: synchronizer, bit timer, framing check, byte_valid/frame_err outputs.
- TX serializer and frame FSM stay in uart_boot_loader.

Test Plan:
- Good frame: A5 02 00 13 00 00 00 6F 00 00 00 7E -> two writes, (addr 0, 0x00000013) then (addr 4, 0x0000006F). cpu_rst_n stays 0 until the 0x4B stop bit ends; then done=1.
- Bad checksum: same frame with CSUM=0x7F -> both writes occur, tx sends 0x45, error=1, cpu_rst_n returns to 1.
- Oversize: A5 01 08 (N=2049) -> no mem_we, immediate 0x45, error=1.
- Line noise: 0x00, 0x11 before A5, plus a 100-cycle low glitch on rx in IDLE -> no state change, busy stays 0.
- Stall: A5 01 00 13, then silence -> 0x45 after TIMEOUT_CYCLES, cpu_rst_n=1.
- Reset: assert rst during the second data word -> all outputs at reset values, no further mem_we; the next good frame loads correctly.
